// File: rtl/note_player_pkg.sv
// Shared widths, FSM encoding and the phase-to-triangle mapping for note_player.
package note_player_pkg;

  localparam int unsigned NOTE_WIDTH     = 6;
  localparam int unsigned DURATION_WIDTH = 6;
  localparam int unsigned PHASE_WIDTH    = 20;
  localparam int unsigned SAMPLE_WIDTH   = 16;

  typedef enum logic {
    StIdle    = 1'b0,
    StPlaying = 1'b1
  } state_e;

  // Top 16 phase bits fold into a triangle, then flip the MSB to re-centre it as signed.
  function automatic logic [SAMPLE_WIDTH-1:0] phase_to_sample(
    input logic [PHASE_WIDTH-1:0] phase
  );
    logic [SAMPLE_WIDTH-1:0] p;
    logic [SAMPLE_WIDTH-1:0] t;
    p = phase[PHASE_WIDTH-1 -: SAMPLE_WIDTH];
    t = {p[SAMPLE_WIDTH-2:0], 1'b0};
    if (p[SAMPLE_WIDTH-1]) begin
      t = ~t;
    end
    return t ^ {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Bundle between one song_reader voice slot / mixer and one note_player.
interface note_player_if;
  import note_player_pkg::*;

  logic                      play_enable;
  logic [NOTE_WIDTH-1:0]     note_to_load;
  logic [DURATION_WIDTH-1:0] duration_to_load;
  logic                      load_new_note;
  logic                      beat;
  logic                      generate_next_sample;
  logic [SAMPLE_WIDTH-1:0]   sample_out;
  logic                      new_sample_ready;
  logic                      note_done;

  modport master (
    output play_enable, note_to_load, duration_to_load, load_new_note, beat,
           generate_next_sample,
    input  sample_out, new_sample_ready, note_done
  );

  modport slave (
    input  play_enable, note_to_load, duration_to_load, load_new_note, beat,
           generate_next_sample,
    output sample_out, new_sample_ready, note_done
  );

endinterface

// File: rtl/note_player_note_to_step.sv
// Note index to phase increment at 48 kHz, scaled to 2^20 (A4 = note 49 = 9612).
module note_to_step
  import note_player_pkg::*;
(
  input  logic [NOTE_WIDTH-1:0]  i_note,
  output logic [PHASE_WIDTH-1:0] o_step
);

  // Offline-generated table; note 0 is a rest and never advances the phase.
  always_comb begin
    o_step = '0;
    case (i_note)
      6'd1:  o_step = 20'd601;   6'd2:  o_step = 20'd636;   6'd3:  o_step = 20'd674;
      6'd4:  o_step = 20'd714;   6'd5:  o_step = 20'd757;   6'd6:  o_step = 20'd802;
      6'd7:  o_step = 20'd850;   6'd8:  o_step = 20'd900;   6'd9:  o_step = 20'd954;
      6'd10: o_step = 20'd1010;  6'd11: o_step = 20'd1070;  6'd12: o_step = 20'd1134;
      6'd13: o_step = 20'd1201;  6'd14: o_step = 20'd1273;  6'd15: o_step = 20'd1349;
      6'd16: o_step = 20'd1429;  6'd17: o_step = 20'd1514;  6'd18: o_step = 20'd1604;
      6'd19: o_step = 20'd1699;  6'd20: o_step = 20'd1800;  6'd21: o_step = 20'd1907;
      6'd22: o_step = 20'd2021;  6'd23: o_step = 20'd2141;  6'd24: o_step = 20'd2268;
      6'd25: o_step = 20'd2403;  6'd26: o_step = 20'd2546;  6'd27: o_step = 20'd2697;
      6'd28: o_step = 20'd2858;  6'd29: o_step = 20'd3028;  6'd30: o_step = 20'd3208;
      6'd31: o_step = 20'd3398;  6'd32: o_step = 20'd3600;  6'd33: o_step = 20'd3815;
      6'd34: o_step = 20'd4041;  6'd35: o_step = 20'd4282;  6'd36: o_step = 20'd4536;
      6'd37: o_step = 20'd4806;  6'd38: o_step = 20'd5092;  6'd39: o_step = 20'd5395;
      6'd40: o_step = 20'd5715;  6'd41: o_step = 20'd6055;  6'd42: o_step = 20'd6415;
      6'd43: o_step = 20'd6797;  6'd44: o_step = 20'd7201;  6'd45: o_step = 20'd7629;
      6'd46: o_step = 20'd8083;  6'd47: o_step = 20'd8563;  6'd48: o_step = 20'd9072;
      6'd49: o_step = 20'd9612;  6'd50: o_step = 20'd10184; 6'd51: o_step = 20'd10789;
      6'd52: o_step = 20'd11431; 6'd53: o_step = 20'd12110; 6'd54: o_step = 20'd12830;
      6'd55: o_step = 20'd13593; 6'd56: o_step = 20'd14402; 6'd57: o_step = 20'd15258;
      6'd58: o_step = 20'd16165; 6'd59: o_step = 20'd17127; 6'd60: o_step = 20'd18145;
      6'd61: o_step = 20'd19224; 6'd62: o_step = 20'd20367; 6'd63: o_step = 20'd21578;
      default: o_step = '0;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// One voice: holds a note for a number of beats and emits a triangle sample per strobe.
module note_player
  import note_player_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  note_player_if.slave bus
);

  state_e                    r_state, w_state_next;
  logic [DURATION_WIDTH-1:0] r_counter, w_counter_next;
  logic [NOTE_WIDTH-1:0]     r_note, w_note_next;
  logic [PHASE_WIDTH-1:0]    r_phase, w_phase_next;
  logic [PHASE_WIDTH-1:0]    w_step;
  logic                      w_load_ok;
  logic                      w_run;
  logic                      w_active;
  logic                      r_pend;
  logic                      r_pend_active;
  logic                      r_ready;
  logic [SAMPLE_WIDTH-1:0]   r_sample;

  note_to_step u_note_to_step (
    .i_note (r_note),
    .o_step (w_step)
  );

  assign w_load_ok = bus.load_new_note && (bus.duration_to_load != '0);
  assign w_run     = (r_state == StPlaying) && bus.play_enable;
  assign w_active  = w_run && (r_note != '0);

  // Voice state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_counter <= '0;
      r_note    <= '0;
      r_phase   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_counter <= w_counter_next;
      r_note    <= w_note_next;
      r_phase   <= w_phase_next;
    end
  end

  // Next state: a valid load always wins, even over the final beat.
  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_note_next    = r_note;
    w_phase_next   = r_phase;
    if (w_load_ok) begin
      w_state_next   = StPlaying;
      w_counter_next = bus.duration_to_load;
      w_note_next    = bus.note_to_load;
      w_phase_next   = '0;
    end else if (w_run) begin
      if (bus.beat) begin
        w_counter_next = r_counter - 1'b1;
        if (r_counter == DURATION_WIDTH'(1)) begin
          w_state_next = StIdle;
        end
      end
      if (bus.generate_next_sample && (r_note != '0)) begin
        w_phase_next = r_phase + w_step;
      end
    end
  end

  // Sample pipeline: strobe, then sample from the advanced phase, then ready pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend        <= 1'b0;
      r_pend_active <= 1'b0;
      r_ready       <= 1'b0;
      r_sample      <= '0;
    end else begin
      r_pend        <= bus.generate_next_sample;
      r_pend_active <= w_active;
      r_ready       <= r_pend;
      if (r_pend) begin
        r_sample <= r_pend_active ? phase_to_sample(r_phase) : '0;
      end
    end
  end

  assign bus.note_done        = (r_state == StIdle);
  assign bus.sample_out       = r_sample;
  assign bus.new_sample_ready = r_ready;

endmodule

// File: tb/tb_note_player.sv
// Randomised and directed bench for note_player against a beat/phase reference model.
module tb_note_player;

  logic clk = 1'b0;
  logic reset;

  note_player_if bus ();

  note_player dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  bit          m_playing;
  int          m_left;
  int          m_note;
  int          m_phase;
  int          m_due;
  logic [15:0] m_pend_val;
  logic [15:0] m_sample;

  function automatic int step_of(input int n);
    real f;
    if (n == 0) return 0;
    f = 1048576.0 * 440.0 * (2.0 ** (real'(n - 49) / 12.0)) / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  function automatic logic [15:0] tri_of(input int ph);
    int p;
    int t;
    p = ph / 16;
    if (p < 32768) t = 2 * p;
    else           t = 65535 - 2 * (p - 32768);
    return 16'((t + 32768) % 65536);
  endfunction

  task automatic model_reset();
    m_playing  = 1'b0;
    m_left     = 0;
    m_note     = 0;
    m_phase    = 0;
    m_due      = -1;
    m_pend_val = 16'h0;
    m_sample   = 16'h0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
  task automatic tick(input bit ld, input int nt, input int dur, input bit bt, input bit st,
                      input bit pe);
    bit active;
    bus.load_new_note        = ld;
    bus.note_to_load         = 6'(nt);
    bus.duration_to_load     = 6'(dur);
    bus.beat                 = bt;
    bus.generate_next_sample = st;
    bus.play_enable          = pe;
    @(posedge clk);
    active = m_playing && pe && (m_note != 0);
    if (ld && dur != 0) begin
      m_playing = 1'b1;
      m_left    = dur;
      m_note    = nt;
      m_phase   = 0;
    end else if (m_playing && pe) begin
      if (st && m_note != 0) m_phase = (m_phase + step_of(m_note)) % 1048576;
      if (bt) begin
        m_left--;
        if (m_left == 0) m_playing = 1'b0;
      end
    end
    if (st) begin
      m_due      = cyc + 2;
      m_pend_val = active ? tri_of(m_phase) : 16'h0;
    end
    cyc++;
    #1;
    bus.load_new_note        = 1'b0;
    bus.beat                 = 1'b0;
    bus.generate_next_sample = 1'b0;
    if (cyc == m_due) m_sample = m_pend_val;
  endtask

  task automatic test_reset();
    reset                    = 1'b1;
    bus.play_enable          = 1'b1;
    bus.note_to_load         = '0;
    bus.duration_to_load     = '0;
    bus.load_new_note        = 1'b0;
    bus.beat                 = 1'b0;
    bus.generate_next_sample = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (bus.note_done !== 1'b1) begin
      failures++; $display("FAIL reset_done got=%b exp=1", bus.note_done);
    end
    checks++;
    if (bus.new_sample_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", bus.new_sample_ready);
    end
    checks++;
    if (bus.sample_out !== 16'h0) begin
      failures++; $display("FAIL reset_sample got=%h exp=0000", bus.sample_out);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_beats();
    tick(1'b1, 49, 3, 1'b0, 1'b0, 1'b1);
    if (bus.note_done !== 1'b0) begin
      failures++; $display("FAIL beats_load_done got=%b exp=0", bus.note_done);
    end
    checks++;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 100; i++) begin
        tick(1'b0, 0, 0, (i == 99), 1'b0, 1'b1);
        if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
            bus.sample_out !== m_sample) begin
          failures++;
          $display("FAIL beats cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                   bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                   bus.sample_out, m_sample);
        end
        checks++;
      end
    end
    if (bus.note_done !== 1'b1) begin
      failures++; $display("FAIL beats_end_done got=%b exp=1", bus.note_done);
    end
    checks++;
  endtask

  task automatic test_a4_sample();
    tick(1'b1, 49, 5, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, 0, 1'b0, (i == 0), 1'b1);
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL a4 cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
      if (i == 1 && (bus.new_sample_ready !== 1'b1 || bus.sample_out !== 16'h84B0)) begin
        failures++;
        $display("FAIL a4_value rdy=%b exp=1 sample=%h exp=84b0", bus.new_sample_ready,
                 bus.sample_out);
      end
      if (i == 1) checks++;
    end
  endtask

  task automatic test_rest();
    tick(1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 0, 0, (i == 120 || i == 240), (i % 50 == 10), 1'b1);
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL rest cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
    end
  endtask

  task automatic test_pause();
    bit pe;
    tick(1'b1, 60, 4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 180; i++) begin
      pe = !(i >= 40 && i < 100);
      tick(1'b0, 0, 0, (i == 20 || i == 50 || i == 70 || i == 150), (i % 10 == 5), pe);
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL pause cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
    end
  endtask

  task automatic test_load_on_final_beat();
    tick(1'b1, 49, 2, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 30, 3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, 0, 0, (i == 19 || i == 39 || i == 59), (i % 8 == 3), 1'b1);
      if (i < 59 && bus.note_done !== 1'b0) begin
        failures++; $display("FAIL final_beat_hold cyc=%0d got=%b exp=0", cyc, bus.note_done);
      end
      if (i < 59) checks++;
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL final_beat cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit pe = 1'b1;
    bit prev_st = 1'b0;
    bit st;
    bit ld;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) pe = ~pe;
      st = !prev_st && ($urandom_range(0, 3) == 0);
      ld = !st && !prev_st && ($urandom_range(0, 39) == 0);
      tick(ld, $urandom_range(0, 63), $urandom_range(0, 4), ($urandom_range(0, 9) == 0), st, pe);
      prev_st = st;
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL random cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 55, 5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 0, 0, 1'b0, (i % 3 == 0), 1'b1);
      if (bus.note_done !== !m_playing || bus.new_sample_ready !== (cyc == m_due) ||
          bus.sample_out !== m_sample) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d done=%b exp=%b rdy=%b exp=%b sample=%h exp=%h", cyc,
                 bus.note_done, !m_playing, bus.new_sample_ready, cyc == m_due,
                 bus.sample_out, m_sample);
      end
      checks++;
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    if (bus.note_done !== 1'b1 || bus.sample_out !== 16'h0 || bus.new_sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset done=%b exp=1 sample=%h exp=0000 rdy=%b exp=0", bus.note_done,
               bus.sample_out, bus.new_sample_ready);
    end
    checks++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tick(1'b1, 20, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      if (bus.note_done !== 1'b1) begin
        failures++; $display("FAIL zero_dur_load cyc=%0d got=%b exp=1", cyc, bus.note_done);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_beats();
    test_a4_sample();
    test_rest();
    test_pause();
    test_load_on_final_beat();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
